lcg128_step: RTL
================

Name: lcg128_step

Overview:
- 128-bit linear congruential generator stage feeding the 128-bit permutation stage of the PRNG256 path.
- Computes state' = state*MULT + INC mod 2^128 using a multi-cycle 128x32 slice multiplier (4 slices).
- Presents each new state on a valid/ready output port, so the downstream permutation consumes one word per handshake.
- Seed loading restarts the sequence at any time.

Parameters:
- MULT, 128'h2360ED051FC65DA44385DF649FCCF645, LCG multiplier (odd).
- INC, 128'h5851F42D4C957F2D14057B7EF767814F, LCG increment (odd).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset).
- seed_load  input  1  pulse; load seed_in as state and restart.
- seed_in  input  128  seed value.
- out_ready  input  1  downstream accepts data_out this cycle.
- out_valid  output  1  data_out holds a new LCG state.
- data_out  output  128  latest LCG state (to permutation data_in).
- busy  output  1  high while in CALC.

Behaviour:
- Reset (rst=0, async): state=0, acc=0, step=0, FSM=IDLE, out_valid=0, data_out=0, busy=0.
- FSM states are IDLE, CALC and HOLD.
- IDLE:
  - Waits for seed_load; no output is generated before the first seed.
  - On seed_load at edge E0: state<=seed_in, acc<=0, step<=0, go to CALC.
- CALC (busy=1), step 0..3, one slice per edge:
  - acc <= acc + ((state * MULT[32*step+31:32*step]) << (32*step)), truncated to 128 bits.
  - On the edge with step==3: state<=acc_next+INC (mod 2^128), data_out<=same value, out_valid<=1, go to HOLD.
- Latency:
  - seed_load edge E0, then out_valid asserted after edge E4 (4 cycles).
  - Each next word follows 4 cycles after the accepting handshake edge.
  - Peak throughput is 1 word per 5 cycles.
- HOLD:
  - out_valid=1, data_out stable until out_valid&&out_ready.
  - Handshake edge: out_valid<=0, acc<=0, step<=0, go to CALC.
  - out_ready low means hold indefinitely; no word is lost or skipped.
- seed_load has priority in every state:
  - state<=seed_in, out_valid<=0, acc/step cleared, go to CALC. Any in-progress calculation is aborted.
  - If seed_load coincides with a HOLD handshake, the word counts as consumed and the seed takes effect. The next output is seed*MULT+INC.
- Arithmetic:
  - All sums and products are truncated to 128 bits; no overflow flag.
  - Slice product is 128x32 with only the low 128 bits kept after the shift.
- out_ready is ignored when out_valid=0.
- Reset asserted mid-CALC or mid-HOLD returns all outputs to their reset values immediately.

Optional Feature:
- Macro: LCG128_STEP_CNT_EN
- Defined:
  - Adds output step_cnt [63:0].
  - step_cnt counts completed output handshakes.
  - Cleared by reset and by seed_load.
  - Wraps 2^64-1 to 0.
  - A handshake coinciding with seed_load leaves step_cnt at 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset with rst=0 → out_valid=0, data_out=0, busy=0; no output with out_ready=1 and no seed for 20 cycles.
- seed_in=0, seed_load pulse, out_ready=1 → out_valid rises 4 edges after the load; data_out=0x5851F42D4C957F2D14057B7EF767814F.
- seed_in=1 → first data_out=0x7BB2E1326C5BDCD1578B5AE397347794; then 16 consecutive words with out_ready=1 match a golden 128-bit model; each out_valid is spaced 5 cycles apart.
- Backpressure: out_ready=0 for 10 cycles in HOLD → data_out stable and out_valid=1. On release, one handshake occurs, then the next word appears 4 cycles later.
- seed_load at step==2 of CALC with seed_in=1 → the aborted result never appears; the next output is 0x7BB2E1326C5BDCD1578B5AE397347794.
- Async reset pulsed while out_valid=1 → out_valid and data_out go to 0 without a clock edge. With LCG128_STEP_CNT_EN, step_cnt=0 after reset and after seed_load.

Source files
------------

// File: rtl/lcg128_step.sv
// lcg128_step: 128-bit LCG stage, state' = state*MULT + INC, one 128x32 slice per cycle.
// Define LCG128_STEP_CNT_EN to add the step_cnt handshake counter output.
module lcg128_step #(
    parameter logic [127:0] MULT = 128'h2360ED051FC65DA44385DF649FCCF645,
    parameter logic [127:0] INC  = 128'h5851F42D4C957F2D14057B7EF767814F
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         seed_load,
    input  logic [127:0] seed_in,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [127:0] data_out,
    output logic         busy
`ifdef LCG128_STEP_CNT_EN
    ,
    output logic [63:0]  step_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, CALC, HOLD} fsm_t;
    fsm_t         r_fsm, w_fsm_next;
    logic [127:0] r_state, r_acc, r_data_out;
    logic [1:0]   r_step;
    logic         r_out_valid;
    logic [6:0]   w_shamt;
    logic [31:0]  w_mult_slice;
    logic [127:0] w_prod, w_acc_next, w_result;
    logic         w_fire;
    assign w_shamt      = {r_step, 5'd0};
    assign w_mult_slice = MULT[w_shamt +: 32];
    assign w_prod       = r_state * {96'd0, w_mult_slice};
    assign w_acc_next   = r_acc + (w_prod << w_shamt);
    assign w_result     = w_acc_next + INC;
    assign w_fire       = r_out_valid & out_ready;
    assign out_valid    = r_out_valid;
    assign data_out     = r_data_out;
    assign busy         = (r_fsm == CALC);
    always_comb begin
        w_fsm_next = seed_load                           ? CALC :
                     (r_fsm == CALC && r_step == 2'd3)   ? HOLD :
                     (r_fsm == HOLD && w_fire)           ? CALC : r_fsm;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_fsm <= IDLE;
        else      r_fsm <= w_fsm_next;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= '0;
            r_acc       <= '0;
            r_step      <= '0;
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
        end else if (seed_load) begin
            r_state     <= seed_in;
            r_acc       <= '0;
            r_step      <= '0;
            r_out_valid <= 1'b0;
        end else if (r_fsm == CALC) begin
            r_acc  <= w_acc_next;
            r_step <= r_step + 2'd1;
            if (r_step == 2'd3) begin
                r_state     <= w_result;
                r_data_out  <= w_result;
                r_out_valid <= 1'b1;
            end
        end else if (r_fsm == HOLD && w_fire) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_step      <= '0;
        end
    end
`ifdef LCG128_STEP_CNT_EN
    logic [63:0] r_step_cnt;
    assign step_cnt = r_step_cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           r_step_cnt <= '0;
        else if (seed_load) r_step_cnt <= '0;
        else if (w_fire)    r_step_cnt <= r_step_cnt + 64'd1;
    end
`endif
endmodule
